// File: rtl/voq_sched.sv
// voq_sched: single-iteration iSLIP crossbar scheduler for a 4x4 fixed-length
// cell switch. Each time slot samples the VOQ empty flags once, computes a
// conflict-free ingress/egress match, and issues a one-cycle dequeue strobe to
// every matched ingress. The crossbar select is held until the next issue.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   experimenting scheduling enable, sampled in IDLE and on the last WAIT cycle
//   is_empty      VOQ empty flags, bit 4*i+j = ingress i, egress j queue empty
//   sched_en      per-ingress one-cycle dequeue strobe
//   sched_sel     per-ingress egress VOQ to dequeue, bits [2i+1:2i]
//   xbar_valid    per-egress "has a matched source this slot"
//   xbar_sel      per-egress driving ingress, bits [2j+1:2j]
//   slot_cnt      count of completed slots with at least one match (wraps)
//   busy          high whenever the scheduler is not in IDLE
module voq_sched #(
    parameter int unsigned PORT_CNT    = 4,
    parameter int unsigned SLOT_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           experimenting,
    input  logic [PORT_CNT*PORT_CNT-1:0]   is_empty,
    output logic [PORT_CNT-1:0]            sched_en,
    output logic [2*PORT_CNT-1:0]          sched_sel,
    output logic [PORT_CNT-1:0]            xbar_valid,
    output logic [2*PORT_CNT-1:0]          xbar_sel,
    output logic [31:0]                    slot_cnt,
    output logic                           busy
);

    // REQ + MATCH + ISSUE take three cycles; WAIT fills the rest of the slot.
    // The counter loads N-4 and WAIT ends when it reads zero, giving N-3 cycles.
    localparam logic [7:0] WAIT_LOAD = 8'(SLOT_CYCLES - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_MATCH,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [PORT_CNT*PORT_CNT-1:0] req_q, req_d;
    logic [1:0]                   gptr_q [PORT_CNT];
    logic [1:0]                   gptr_d [PORT_CNT];
    logic [1:0]                   aptr_q [PORT_CNT];
    logic [1:0]                   aptr_d [PORT_CNT];
    logic [PORT_CNT-1:0]          sched_en_q, sched_en_d;
    logic [2*PORT_CNT-1:0]        sched_sel_q, sched_sel_d;
    logic [PORT_CNT-1:0]          xbar_valid_q, xbar_valid_d;
    logic [2*PORT_CNT-1:0]        xbar_sel_q, xbar_sel_d;
    logic [31:0]                  slot_cnt_q, slot_cnt_d;
    logic [7:0]                   wait_cnt_q, wait_cnt_d;

    logic                         gnt_vld [PORT_CNT];
    logic [1:0]                   gnt_src [PORT_CNT];
    logic                         acc_vld [PORT_CNT];
    logic [1:0]                   acc_dst [PORT_CNT];

    // Grant: each egress j scans ingresses starting at its grant pointer.
    always_comb begin : grant_stage
        logic [1:0] idx;
        idx = '0;
        for (int unsigned j = 0; j < PORT_CNT; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_src[j] = '0;
            for (int unsigned k = 0; k < PORT_CNT; k++) begin
                idx = gptr_q[j] + 2'(k);
                if (!gnt_vld[j] && req_q[{idx, 2'(j)}]) begin
                    gnt_vld[j] = 1'b1;
                    gnt_src[j] = idx;
                end
            end
        end
    end

    // Accept: each ingress i scans granting egresses from its accept pointer.
    always_comb begin : accept_stage
        logic [1:0] jdx;
        jdx = '0;
        for (int unsigned i = 0; i < PORT_CNT; i++) begin
            acc_vld[i] = 1'b0;
            acc_dst[i] = '0;
            for (int unsigned k = 0; k < PORT_CNT; k++) begin
                jdx = aptr_q[i] + 2'(k);
                if (!acc_vld[i] && gnt_vld[jdx] && (gnt_src[jdx] == 2'(i))) begin
                    acc_vld[i] = 1'b1;
                    acc_dst[i] = jdx;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (experimenting) state_d = S_REQ;
            S_REQ:   state_d = S_MATCH;
            S_MATCH: state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_cnt_q == '0) state_d = experimenting ? S_REQ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath. The match is registered straight into the output registers at
    // the MATCH->ISSUE edge, so the strobe is visible exactly in ISSUE and
    // cleared again on the following edge.
    always_comb begin : datapath
        req_d        = req_q;
        gptr_d       = gptr_q;
        aptr_d       = aptr_q;
        sched_en_d   = '0;
        sched_sel_d  = sched_sel_q;
        xbar_valid_d = xbar_valid_q;
        xbar_sel_d   = xbar_sel_q;
        slot_cnt_d   = slot_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        unique case (state_q)
            S_IDLE: xbar_valid_d = '0;
            S_REQ:  req_d = ~is_empty;
            S_MATCH: begin
                xbar_valid_d = '0;
                xbar_sel_d   = '0;
                for (int unsigned i = 0; i < PORT_CNT; i++) begin
                    if (acc_vld[i]) begin
                        sched_en_d[i]                        = 1'b1;
                        sched_sel_d[2*i +: 2]                = acc_dst[i];
                        xbar_valid_d[acc_dst[i]]             = 1'b1;
                        xbar_sel_d[{acc_dst[i], 1'b0} +: 2]  = 2'(i);
                        gptr_d[acc_dst[i]]                   = 2'(i) + 2'd1;
                        aptr_d[i]                            = acc_dst[i] + 2'd1;
                    end
                end
                if (|sched_en_d) slot_cnt_d = slot_cnt_q + 32'd1;
            end
            S_ISSUE: wait_cnt_d = WAIT_LOAD;
            S_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end else if (!experimenting) begin
                    xbar_valid_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin : data_reg
        if (reset) begin
            req_q        <= '0;
            sched_en_q   <= '0;
            sched_sel_q  <= '0;
            xbar_valid_q <= '0;
            xbar_sel_q   <= '0;
            slot_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            for (int unsigned p = 0; p < PORT_CNT; p++) begin
                gptr_q[p] <= '0;
                aptr_q[p] <= '0;
            end
        end else begin
            req_q        <= req_d;
            sched_en_q   <= sched_en_d;
            sched_sel_q  <= sched_sel_d;
            xbar_valid_q <= xbar_valid_d;
            xbar_sel_q   <= xbar_sel_d;
            slot_cnt_q   <= slot_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            gptr_q       <= gptr_d;
            aptr_q       <= aptr_d;
        end
    end

    // Outputs.
    always_comb begin : outputs
        sched_en   = sched_en_q;
        sched_sel  = sched_sel_q;
        xbar_valid = xbar_valid_q;
        xbar_sel   = xbar_sel_q;
        slot_cnt   = slot_cnt_q;
        busy       = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_voq_sched.sv
// Self-checking bench for voq_sched: directed slots from the test plan plus
// randomized VOQ occupancy, compared against a slot-level iSLIP model.
module tb_voq_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        experimenting;
    logic [15:0] is_empty;
    logic [3:0]  sched_en;
    logic [7:0]  sched_sel;
    logic [3:0]  xbar_valid;
    logic [7:0]  xbar_sel;
    logic [31:0] slot_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Slot-level reference state.
    int          mg [4];
    int          ma [4];
    logic [7:0]  m_ss;
    logic [3:0]  m_en;
    logic [3:0]  m_xv;
    logic [7:0]  m_xs;
    logic [31:0] m_cnt;

    // Values captured in the ISSUE cycle of the last slot.
    logic [3:0]  cap_en;
    logic [7:0]  cap_ss;
    logic [3:0]  cap_xv;
    logic [7:0]  cap_xs;

    voq_sched #(.PORT_CNT(4), .SLOT_CYCLES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .experimenting (experimenting),
        .is_empty      (is_empty),
        .sched_en      (sched_en),
        .sched_sel     (sched_sel),
        .xbar_valid    (xbar_valid),
        .xbar_sel      (xbar_sel),
        .slot_cnt      (slot_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            mg[p] = 0;
            ma[p] = 0;
        end
        m_ss  = '0;
        m_en  = '0;
        m_xv  = '0;
        m_xs  = '0;
        m_cnt = '0;
    endtask

    // One iSLIP iteration on the snapshot; returns expected outputs in m_*.
    task automatic model_slot(input logic [15:0] emp);
        logic [15:0] req;
        int gs [4];
        int acc [4];
        req  = ~emp;
        m_en = '0;
        m_xv = '0;
        m_xs = '0;
        for (int j = 0; j < 4; j++) begin
            gs[j] = -1;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (mg[j] + k) % 4;
                if (gs[j] < 0 && req[4*i + j]) gs[j] = i;
            end
        end
        for (int i = 0; i < 4; i++) begin
            acc[i] = -1;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (ma[i] + k) % 4;
                if (acc[i] < 0 && gs[j] == i) acc[i] = j;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i] >= 0) begin
                m_en[i]             = 1'b1;
                m_ss[2*i +: 2]      = 2'(acc[i]);
                m_xv[acc[i]]        = 1'b1;
                m_xs[2*acc[i] +: 2] = 2'(i);
                mg[acc[i]]          = (i + 1) % 4;
                ma[i]               = (acc[i] + 1) % 4;
            end
        end
        if (m_en != '0) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},   sched_en,   0);
        check({tag, "_ss"},   sched_sel,  0);
        check({tag, "_xv"},   xbar_valid, 0);
        check({tag, "_xs"},   xbar_sel,   0);
        check({tag, "_cnt"},  slot_cnt,   0);
        check({tag, "_busy"}, busy,       0);
    endtask

    // Entered in the REQ cycle; returns in the cycle after the last WAIT cycle.
    task automatic run_slot(input logic [15:0] emp, input bit drop_exp, input bit wobble);
        int seen [4];
        int dup;
        check("req_busy", busy, 1);
        check("req_en", sched_en, 0);
        is_empty = emp;
        model_slot(emp);
        step();                                   // MATCH
        is_empty = 16'($urandom);                 // must not affect this slot
        if (wobble) experimenting = 1'($urandom_range(0, 1));
        check("match_en", sched_en, 0);
        step();                                   // ISSUE
        cap_en = sched_en;
        cap_ss = sched_sel;
        cap_xv = xbar_valid;
        cap_xs = xbar_sel;
        check("issue_en",  sched_en,   m_en);
        check("issue_ss",  sched_sel,  m_ss);
        check("issue_xv",  xbar_valid, m_xv);
        check("issue_xs",  xbar_sel,   m_xs);
        check("issue_cnt", slot_cnt,   m_cnt);
        dup = 0;
        for (int p = 0; p < 4; p++) seen[p] = 0;
        for (int j = 0; j < 4; j++) begin
            if (xbar_valid[j]) begin
                int src;
                src = int'(xbar_sel[2*j +: 2]);
                if (seen[src] != 0) dup = 1;
                seen[src] = 1;
                check("xcons", {sched_en[src], sched_sel[2*src +: 2]}, {1'b1, 2'(j)});
            end
        end
        check("dup_src", dup, 0);
        step();                                   // first WAIT cycle
        experimenting = drop_exp ? 1'b0 : 1'b1;
        for (int w = 0; w < 5; w++) begin
            check("wait_en",   sched_en,   0);
            check("wait_xv",   xbar_valid, m_xv);
            check("wait_xs",   xbar_sel,   m_xs);
            check("wait_busy", busy,       1);
            step();
        end
        if (drop_exp) begin
            check("idle_xv",   xbar_valid, 0);
            check("idle_busy", busy,       0);
            check("idle_ss",   sched_sel,  m_ss);
        end
    endtask

    // Called in REQ with experimenting = 1; returns in the next REQ cycle.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        check_zero(tag);
        model_reset();
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        experimenting = 1'b0;
        is_empty      = '1;
        model_reset();
        step();
        step();
        check_zero("por");
        reset = 1'b0;
        step();
        check("idle_hold", busy, 0);
        experimenting = 1'b1;
        step();                                   // REQ

        // No requests at all.
        for (int s = 0; s < 2; s++) begin
            run_slot(16'hFFFF, 1'b0, 1'b0);
            check("empty_en", cap_en, 0);
            check("empty_xv", cap_xv, 0);
            check("empty_cnt", slot_cnt, 0);
        end

        // Single request ingress 0 -> egress 0.
        run_slot(16'hFFFE, 1'b0, 1'b0);
        check("one_en",  cap_en, 4'b0001);
        check("one_ss",  cap_ss[1:0], 0);
        check("one_xv",  cap_xv, 4'b0001);
        check("one_cnt", slot_cnt, 1);

        // Full load from reset pointers: 1, 2, 3, 4 matches.
        do_reset("rst_a");
        for (int s = 0; s < 4; s++) begin
            run_slot(16'h0000, 1'b0, 1'b0);
            if (s == 0) check("full_s1_en", cap_en, 4'b0001);
            if (s == 3) check("full_s4_en", cap_en, 4'b1111);
        end

        // Ingress 1 and 2 contend for egress 3 only.
        for (int s = 0; s < 4; s++) begin
            run_slot(16'hF77F, 1'b0, 1'b0);
            check("rr_en", cap_en, (s % 2 == 0) ? 4'b0010 : 4'b0100);
            check("rr_xs", cap_xs[7:6], (s % 2 == 0) ? 2'd1 : 2'd2);
            check("rr_xv", cap_xv, 4'b1000);
        end

        // Reset landing in the ISSUE cycle, then a clean restart.
        is_empty = 16'h0000;
        step();                                   // MATCH
        step();                                   // ISSUE
        check("pre_rst_busy", busy, 1);
        do_reset("rst_issue");
        run_slot(16'h0000, 1'b0, 1'b0);
        check("restart_en", cap_en, 4'b0001);
        check("restart_xs", cap_xs, 8'h00);

        // Random occupancy with experimenting toggling mid-slot.
        for (int s = 0; s < 24; s++) begin
            logic [15:0] e;
            e = (s % 2 == 0) ? 16'($urandom | $urandom) : 16'($urandom & $urandom);
            run_slot(e, 1'b0, 1'b1);
        end

        // Drop experimenting one cycle after ISSUE; slot completes, then IDLE.
        run_slot(16'($urandom & 16'h5A5A), 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            check("post_en",   sched_en,   0);
            check("post_xv",   xbar_valid, 0);
            check("post_busy", busy,       0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
